// File: rtl/riscv_pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// scoreboard entries and the source/destination match helper.
package riscv_pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
    logic             load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // x0 is never a real producer, so an entry writing rd = 0 cannot match.
  function automatic logic src_hit(input logic             use_src,
                                   input logic [REG_W-1:0] rs,
                                   input sb_entry_t        e);
    return use_src && e.we && (e.rd != '0) && (rs == e.rd);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry EX/MEM/WB record of in-flight destination registers.
// Shifts every cycle; a bubble (we = 0) replaces the ID entry on request.
module hazard_scoreboard
  import riscv_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      bubble_i,
  input  sb_entry_t id_i,
  output sb_entry_t ex_o,
  output sb_entry_t mem_o,
  output sb_entry_t wb_o
);

  sb_entry_t ex_d;
  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;

  always_comb begin
    ex_d = bubble_i ? SB_BUBBLE : id_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= SB_BUBBLE;
      mem_q <= SB_BUBBLE;
      wb_q  <= SB_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush control and operand forwarding for the five-stage core; stall/flush are
// combinational, fwd_* registered one cycle. HAZARD_FWD_EN enables forwarding/bypass.
module hazard_unit
  import riscv_pipe_pkg::*;
#(
  parameter int REG_W = riscv_pipe_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_byp_a,
  output logic             id_byp_b
);

  sb_entry_t id_e;
  sb_entry_t ex_e;
  sb_entry_t mem_e;
  sb_entry_t wb_e;

  logic hit_ex_a, hit_ex_b;
  logic hit_mem_a, hit_mem_b;
  logic hit_wb_a, hit_wb_b;
  logic stall_raw;
  logic stall;
  logic flush;
  logic ex_bubble;

  always_comb begin
    id_e = '{rd: id_rd, we: id_reg_write, load: id_mem_read};
  end

  hazard_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (ex_bubble),
    .id_i     (id_e),
    .ex_o     (ex_e),
    .mem_o    (mem_e),
    .wb_o     (wb_e)
  );

  assign hit_ex_a  = src_hit(id_use_rs1, id_rs1, ex_e);
  assign hit_ex_b  = src_hit(id_use_rs2, id_rs2, ex_e);
  assign hit_mem_a = src_hit(id_use_rs1, id_rs1, mem_e);
  assign hit_mem_b = src_hit(id_use_rs2, id_rs2, mem_e);
  assign hit_wb_a  = src_hit(id_use_rs1, id_rs1, wb_e);
  assign hit_wb_b  = src_hit(id_use_rs2, id_rs2, wb_e);

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign stall_raw = id_valid && ex_e.load && (hit_ex_a || hit_ex_b);
`else
  assign stall_raw = id_valid && (hit_ex_a || hit_ex_b || hit_mem_a ||
                                  hit_mem_b || hit_wb_a || hit_wb_b);
`endif

  // A taken branch kills the ID instruction, so any stall it would cause is moot.
  assign flush = !rst && ex_branch_taken;
  assign stall = !rst && stall_raw && !ex_branch_taken;

  assign pc_stall   = stall;
  assign ifid_stall = stall;
  assign ifid_flush = flush;
  assign idex_flush = stall || flush;
  assign ex_bubble  = idex_flush || !id_valid;

`ifdef HAZARD_FWD_EN
  fwd_sel_t fwd_a_d, fwd_b_d;
  fwd_sel_t fwd_a_q, fwd_b_q;

  // Selects are computed for the stage each producer will occupy one cycle later.
  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!ex_bubble) begin
      if (hit_ex_a)       fwd_a_d = FWD_MEM;
      else if (hit_mem_a) fwd_a_d = FWD_WB;
      if (hit_ex_b)       fwd_b_d = FWD_MEM;
      else if (hit_mem_b) fwd_b_d = FWD_WB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a    = fwd_a_q;
  assign fwd_b    = fwd_b_q;
  assign id_byp_a = hit_wb_a;
  assign id_byp_b = hit_wb_b;
`else
  assign fwd_a    = FWD_RF;
  assign fwd_b    = FWD_RF;
  assign id_byp_a = 1'b0;
  assign id_byp_b = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; expectations follow the HAZARD_FWD_EN build setting.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic       ex_branch_taken;
  logic       pc_stall, ifid_stall, ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       id_byp_a, id_byp_b;

  int total = 0;
  int bad   = 0;

  logic [2:0] stl;
  logic [3:0] ctl;
  logic [9:0] all_o;
  assign stl   = {pc_stall, ifid_stall, idex_flush};
  assign ctl   = {pc_stall, ifid_stall, ifid_flush, idex_flush};
  assign all_o = {pc_stall, ifid_stall, ifid_flush, idex_flush, fwd_a, fwd_b, id_byp_a, id_byp_b};

  always #5 clk = ~clk;

  hazard_unit #(.REG_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .id_byp_a        (id_byp_a),
    .id_byp_b        (id_byp_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic ld);
    id_valid     = v;
    id_rs1       = r1;
    id_use_rs1   = u1;
    id_rs2       = r2;
    id_use_rs2   = u2;
    id_rd        = rd;
    id_reg_write = we;
    id_mem_read  = ld;
    #1;
  endtask

  task automatic drain;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    tick;
  endtask

  initial begin
    // Reset held with a live instruction and a taken branch: every output must be 0.
    rst = 1'b1;
    ex_branch_taken = 1'b1;
    set_id(1, 5, 1, 0, 0, 5, 1, 0);
    #11;
    check("reset_outputs", 32'(all_o), 0);
    rst = 1'b0;
    ex_branch_taken = 1'b0;
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    check("empty_sb_nostall", 32'(stl), 0);
    tick;

    // add x5,x1,x2 followed by sub x9,x5,x2
    set_id(1, 1, 1, 2, 1, 5, 1, 0);
    check("add_x5_nostall", 32'(stl), 0);
    tick;
`ifdef HAZARD_FWD_EN
    set_id(1, 5, 1, 2, 1, 9, 1, 0);
    check("exex_nostall", 32'(stl), 0);
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    check("exex_fwd_a", 32'(fwd_a), 2);
    check("exex_fwd_b", 32'(fwd_b), 0);
    tick;
    set_id(1, 5, 1, 5, 0, 0, 0, 0);
    check("byp_wb_a", 32'(id_byp_a), 1);
    check("byp_wb_b_unused", 32'(id_byp_b), 0);
    check("byp_nostall", 32'(stl), 0);
    tick;
`else
    set_id(1, 5, 1, 2, 1, 9, 1, 0);
    check("dep_stall1", 32'(stl), 7);
    check("dep_fwd_a1", 32'(fwd_a), 0);
    tick;
    check("dep_stall2", 32'(stl), 7);
    tick;
    check("dep_stall3", 32'(stl), 7);
    check("dep_byp_off", 32'(id_byp_a), 0);
    tick;
    check("dep_release", 32'(stl), 0);
    tick;
    check("dep_fwd_a_ex", 32'(fwd_a), 0);
`endif
    drain;

    // lw x7 followed by add x8,x7,x7
    set_id(1, 1, 1, 0, 0, 7, 1, 1);
    check("lw_nostall", 32'(stl), 0);
    tick;
    set_id(1, 7, 1, 7, 1, 8, 1, 0);
    check("lu_stall1", 32'(stl), 7);
    check("lu_no_ifid_flush", 32'(ifid_flush), 0);
    tick;
`ifdef HAZARD_FWD_EN
    check("lu_release", 32'(stl), 0);
    check("lu_fwd_bubble", 32'(fwd_a), 0);
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    check("lu_fwd_a", 32'(fwd_a), 1);
    check("lu_fwd_b", 32'(fwd_b), 1);
`else
    check("lu_stall2", 32'(stl), 7);
    tick;
    check("lu_stall3", 32'(stl), 7);
    tick;
    check("lu_release", 32'(stl), 0);
    tick;
    check("lu_fwd_a", 32'(fwd_a), 0);
`endif
    drain;

    // Taken branch during a load-use condition: flush wins, no stall.
    set_id(1, 1, 1, 0, 0, 7, 1, 1);
    tick;
    ex_branch_taken = 1'b1;
    set_id(1, 7, 1, 7, 1, 8, 1, 0);
    check("br_ctl", 32'(ctl), 4'b0011);
    tick;
    ex_branch_taken = 1'b0;
    set_id(1, 8, 1, 0, 0, 0, 0, 0);
    check("br_ex_bubble", 32'(stl), 0);
    check("br_flush_drop", 32'(ifid_flush), 0);
    check("br_fwd_a", 32'(fwd_a), 0);
    tick;
    drain;

    // x0 writer then x0 reader
    set_id(1, 0, 0, 0, 0, 0, 1, 0);
    tick;
    set_id(1, 0, 1, 0, 1, 3, 1, 0);
    check("x0_nostall", 32'(stl), 0);
    tick;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    check("x0_fwd", 32'({fwd_a, fwd_b}), 0);
    drain;

    // Invalid ID: no stall, and its destination becomes a bubble.
    set_id(1, 1, 1, 0, 0, 12, 1, 0);
    tick;
    set_id(0, 12, 1, 0, 0, 13, 1, 0);
    check("inv_nostall", 32'(stl), 0);
    tick;
    set_id(1, 13, 1, 0, 0, 0, 0, 0);
    check("inv_bubble", 32'(stl), 0);
    tick;
    drain;

    // Reset arriving mid-stall drops the stall and clears the scoreboard.
    set_id(1, 1, 1, 0, 0, 5, 1, 1);
    tick;
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    check("mid_stall_pre", 32'(stl), 7);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 32'(all_o), 0);
    rst = 1'b0;
    #1;
    check("mid_rst_cleared", 32'(stl), 0);
    tick;
    check("post_rst_nostall", 32'(stl), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RISC-V core. It drives the stall and flush inputs of the PC and the IF/ID register, and bubbles the ID/EX register. It tracks in-flight destination registers in a three-entry EX/MEM/WB scoreboard and produces registered EX-stage forwarding selects plus combinational ID-stage write-back bypass selects.

## Interface
- Parameters:
  - `REG_W`, 5: register address width.
- Ports:
  - `clk` in 1: core clock, rising edge.
  - `rst` in 1: asynchronous, active-high reset.
  - `id_valid` in 1: IF/ID holds a real instruction.
  - `id_rs1`, `id_rs2` in `REG_W`: ID source registers.
  - `id_use_rs1`, `id_use_rs2` in 1: the ID instruction actually reads rs1 / rs2.
  - `id_rd` in `REG_W`: ID destination register.
  - `id_reg_write` in 1: the ID instruction writes rd.
  - `id_mem_read` in 1: the ID instruction is a load.
  - `ex_branch_taken` in 1: the EX instruction redirects the PC this cycle.
  - `pc_stall` out 1: hold the PC.
  - `ifid_stall` out 1: hold IF/ID.
  - `ifid_flush` out 1: clear IF/ID to a bubble.
  - `idex_flush` out 1: load a bubble into ID/EX.
  - `fwd_a`, `fwd_b` out 2: EX operand select. 00 = register file, 01 = WB result, 10 = MEM ALU result. Registered.
  - `id_byp_a`, `id_byp_b` out 1: ID operand takes the WB write data. Combinational.

## Operation
- **Scoreboard entries** (EX, MEM, WB) each hold {rd, we, load}. Every cycle without reset the entries shift:
  - WB ← MEM
  - MEM ← EX
  - EX ← ID entry, or a bubble (we=0) when `idex_flush`.
- **Register x0:** rd = 0 never matches any source, and an entry with rd = 0 never matches.
- **Match:** a source register matches a stage when `id_use_rsN`, the stage's `we` is set, and `rsN == rd`.
- **Load-use:** any source matches EX while EX.load = 1.
  - Assert `pc_stall` = `ifid_stall` = `idex_flush` = 1 for exactly one cycle.
  - The bubble then advances, so the next cycle sees the producer in MEM.
- **Branch:** `ex_branch_taken` asserts `ifid_flush` = `idex_flush` = 1 and forces `pc_stall` = `ifid_stall` = 0.
  - Flush has priority over any stall computed in the same cycle.
- **When `id_valid` = 0:** no stall is generated, and the EX entry receives a bubble.
- **Forwarding priority:** MEM is checked before WB (the youngest producer wins).
  - The select for the ID instruction is registered when it enters EX.
  - On a stall or flush, the registered select is 00.
- **ID bypass:** `id_byp_N` = 1 when a source matches WB. The register bank is written at the clock edge and read combinationally, so ID must take the WB data directly.

## Timing
- **Reset** (asynchronous, immediate): all scoreboard entries get we = 0, rd = 0, load = 0.
  - All outputs are 0: `pc_stall`, `ifid_stall`, `ifid_flush`, `idex_flush`, `fwd_a` = `fwd_b` = 00, `id_byp_a` = `id_byp_b` = 0.
- Stall and flush outputs are combinational from the ID inputs and the scoreboard, all in the same cycle.
- `fwd_*` are registered with one-cycle latency and valid during the instruction's EX cycle.
- Load-use costs exactly 1 bubble with forwarding. Back-to-back dependent loads each cost 1.
- A branch flush in the same cycle as a load-use condition results in flush only; the stall is dropped.
- If reset asserts mid-stall, the stall drops immediately and the scoreboard is cleared.

## Configuration
- **`HAZARD_FWD_EN` defined:** behaviour as above.
- **`HAZARD_FWD_EN` undefined:**
  - `fwd_*` are tied to 00 and `id_byp_*` to 0.
  - Any source match against EX, MEM or WB stalls (`pc_stall` = `ifid_stall` = `idex_flush` = 1) until no match remains.
  - A dependency on the immediately preceding instruction therefore costs 3 bubbles.
  - Branch flush priority is unchanged.

## Structure
- **Package `riscv_pipe_pkg`:**
  - `REG_W`
  - `fwd_sel_t` enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - `sb_entry_t` packed struct {rd, we, load}.
- **Sub-module `hazard_scoreboard`:**
  - Three-stage shift of `sb_entry_t` with async reset and bubble insert.
  - Exposes the EX/MEM/WB entries.
- The top level holds match logic, stall/flush priority and the forwarding registers.

## Test plan
- **Reset:** `rst` = 1 with `id_valid` = 1, `id_rs1` = 5 → all outputs 0. After release, an empty scoreboard gives no stall.
- **EX→EX forwarding (`HAZARD_FWD_EN`):** `add x5` then `add x6,x5,x1` back-to-back → no stall; `fwd_a` = 10 in the second instruction's EX cycle.
- **Load-use:** `lw x7` then `add x8,x7,x7` → exactly one cycle of `pc_stall` = `ifid_stall` = `idex_flush` = 1; then `fwd_a` = `fwd_b` = 01.
- **Branch priority:** `ex_branch_taken` = 1 while a load-use condition is present → `ifid_flush` = `idex_flush` = 1, `pc_stall` = 0; the EX entry becomes a bubble (we = 0).
- **x0 and ID bypass:** a writer of x0 followed by a reader of x0 → no stall, `fwd` = 00. A producer sitting in WB while ID reads the same rd → `id_byp_a` = 1.
- **Build without `HAZARD_FWD_EN`:** `add x5` then `sub x9,x5,x2` → 3 consecutive stall cycles, `fwd_a` stays 00.
